// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, result-entry type and flag helper for the ALU units
//   DATA_W / RD_W : default result and register-index widths
//   result_entry_t: {result, rd, z, n, setflags}
//   flags_of      : architectural {z, n} of a result word
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int RD_W = 5;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              z;
    logic              n;
    logic              setflags;
  } result_entry_t;
  function automatic logic [1:0] flags_of(input logic [DATA_W-1:0] result);
    return {result == '0, result[DATA_W-1]};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 FIFO with registered valid/ready handshakes
//   in_valid_i/in_ready_o/wdata_i   : write side, push on valid && ready
//   out_valid_o/out_ready_i/rdata_o : read side, pop on valid && ready
//   count_o                         : occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic ready_q, valid_q, push, pop;
  assign push = in_valid_i && ready_q;
  assign pop = valid_q && out_ready_i;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // ready/valid are registered from next occupancy, so a pop never reopens ready in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= count_d < CW'(DEPTH);
      valid_q <= count_d != '0;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= wdata_i;
  assign rdata_o = mem_q[rptr_q];
  assign in_ready_o = ready_q;
  assign out_valid_o = valid_q;
  assign count_o = count_q;
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO of ALU results with status-flag commit and producer flag check
//   in_*      : producer handshake and entry fields
//   out_*     : writeback handshake and head entry fields
//   status_z/status_n : flags committed by retiring setflags entries
//   flag_err  : sticky producer Z/N mismatch; flags_clr clears status and error
//   count     : occupancy
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int RD_W = alu_pkg::RD_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_z,
  input  logic                       in_n,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       in_setflags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [RD_W-1:0]            out_rd,
  output logic                       out_z,
  output logic                       out_n,
  output logic                       status_z,
  output logic                       status_n,
  output logic                       flag_err,
  input  logic                       flags_clr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              z;
    logic              n;
    logic              setflags;
  } entry_t;
  entry_t wr, hd;
  logic push, pop, exp_z, exp_n, mismatch;
  logic status_z_q, status_z_d, status_n_q, status_n_d, flag_err_q, flag_err_d;
  assign wr = '{result: in_result, rd: in_rd, z: in_z, n: in_n, setflags: in_setflags};
  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .wdata_i(wr),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .rdata_o(hd),
    .count_o(count)
  );
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign exp_z = in_result == '0;
  assign exp_n = in_result[DATA_W-1] && !exp_z;
  assign mismatch = (in_z != exp_z) || (in_n != exp_n);
  // clear has priority over both commit and error capture
  always_comb begin
    status_z_d = flags_clr ? 1'b0 : (pop && hd.setflags) ? hd.z : status_z_q;
    status_n_d = flags_clr ? 1'b0 : (pop && hd.setflags) ? hd.n : status_n_q;
    flag_err_d = flags_clr ? 1'b0 : flag_err_q || (push && mismatch);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      status_z_q <= 1'b0;
      status_n_q <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      status_z_q <= status_z_d;
      status_n_q <= status_n_d;
      flag_err_q <= flag_err_d;
    end
  assign out_result = hd.result;
  assign out_rd = hd.rd;
  assign out_z = hd.z;
  assign out_n = hd.n;
  assign status_z = status_z_q;
  assign status_n = status_n_q;
  assign flag_err = flag_err_q;
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the ALU/shift units: captures each result word with its Z/N flags and destination register index.
- Buffers results in a small FIFO with valid/ready handshakes on both sides, decoupling the combinational execute stage from register-file writeback.
- Commits architectural status flags (Z, N) when a flag-setting entry retires.
- Checks flag consistency from the producer and raises a sticky error on any mismatch.

Parameters:
- DATA_W, 32, result width; Z/N semantics refer to bit DATA_W-1.
- RD_W, 5, destination register index width.
- DEPTH, 2, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a result this cycle.
- in_ready  out  1  buffer can accept; registered, equals (count < DEPTH).
- in_result  in  DATA_W  result word (e.g. shifter B output).
- in_z  in  1  producer zero flag.
- in_n  in  1  producer negative flag.
- in_rd  in  RD_W  destination register index.
- in_setflags  in  1  entry updates status flags on retire.
- out_valid  out  1  head entry available.
- out_ready  in  1  writeback consumes the head.
- out_result  out  DATA_W  head result.
- out_rd  out  RD_W  head destination.
- out_z  out  1  head Z.
- out_n  out  1  head N.
- status_z  out  1  committed zero flag.
- status_n  out  1  committed negative flag.
- flag_err  out  1  sticky producer-flag mismatch.
- flags_clr  in  1  synchronous clear of status_z, status_n and flag_err.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset, asynchronous: count=0, out_valid=0, in_ready=1, status_z=0, status_n=0, flag_err=0. FIFO pointers are 0. Payload storage is not reset; out_* data values are don't-care while out_valid=0.
- Push occurs when in_valid && in_ready, at the clock edge. Pop occurs when out_valid && out_ready.
- Latency: an entry pushed at edge k is visible on out_* with out_valid=1 after edge k. There is no combinational in→out path.
- Output ordering is strict FIFO.
- out_* are driven from the head entry. The head is stable while out_valid && !out_ready.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, pointers both advance.
- Full: when count==DEPTH, in_ready=0. A pop in the same cycle does not re-open in_ready combinationally; in_ready rises the following cycle.
- Empty: when count==0, out_valid=0 and out_ready is ignored.
- Pointers wrap modulo DEPTH.
- Flag commit: on a pop whose entry has setflags=1, status_z/status_n take that entry's z/n at the same edge. Entries with setflags=0 leave status unchanged.
- flags_clr: at the edge, status_z=status_n=flag_err=0.
  - flags_clr beats a same-cycle flag commit.
  - flags_clr does not affect FIFO contents.
- Consistency check, applied on push only:
  - expected_z = (in_result == 0).
  - expected_n = in_result[DATA_W-1] && !expected_z.
  - If in_z or in_n differs from the expected value, flag_err is set at that edge and stays set until flags_clr or reset.
  - The mismatching entry is still stored unchanged.
  - If flags_clr and an erroring push occur in the same cycle, flag_err ends at 0 (clear wins).
- Reset asserted mid-operation discards all entries immediately.
- in_valid while in_ready=0 is ignored. The producer must hold its data.

Decomposition:
- Shared package alu_pkg:
  - DATA_W and RD_W defaults.
  - Typedef of a result entry: {result, rd, z, n, setflags}.
  - Function flags_of(result) returning {z, n}, reusable by the ALU units.
- One natural sub-module, sync_fifo: parametric storage, pointers, count, full/empty.
- alu_result_buffer wraps sync_fifo and adds flag commit, the consistency checker and clear logic.

Test Plan:
- Push 0x80000000 (z=0, n=1, setflags=1, rd=3) into an empty buffer with out_ready=1. Expected: out_valid=1 the next cycle with result 0x80000000, rd=3; after the pop edge status_n=1, status_z=0, count=0.
- Hold out_ready=0 and push 3 entries back-to-back. Expected: count=2, in_ready=0 after the second push, the third is not accepted. Then pulse out_ready for one cycle: count=1, and in_ready=1 only on the cycle after the pop.
- At count=1, push and pop in the same cycle. Expected: count stays 1, order is preserved, and out_result shows the second entry after the edge.
- Push result 0x00000000 with in_z=0. Expected: flag_err=1 the next cycle and the entry is still output. Then assert flags_clr together with a setflags pop of z=1. Expected: flag_err=0, status_z=0.
- Pop an entry with setflags=0 carrying n=1 while status_n=1 from before. Expected: status_n remains 1. Then pop a setflags=1 entry with z=1. Expected: status_z=1, status_n=0.
- Assert rst_n=0 asynchronously mid-burst with count=2. Expected: immediately count=0, out_valid=0, status flags 0, in_ready=1.
